// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Elastic decode stage for the ARM-subset core. It decodes the instruction,
// evaluates its condition against the status flags and reads the register
// file. The results land in the registered ID/EX entry, which has a
// valid/ready handshake on both sides plus hazard stall and branch flush.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   instr, in_valid/in_ready upstream handshake from IF
//   sr                       status flags {N,Z,C,V}
//   hazard, flush            stall request / branch-taken flush
//   wb_en, wb_dest, wb_data  register file write port
//   src1, src2, two_src      combinational source indices for the hazard unit
//   out_valid/out_ready      downstream handshake to EX
//   exe_cmd .. dest          registered ID/EX entry
//
// Configuration
//   WB_BYPASS_EN  when defined, a write to the register being read in the
//                 accept cycle is forwarded into val_rn/val_rm. When undefined,
//                 the pre-write contents are captured.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        sr,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_o,
  output logic              branch,
  output logic              s_o,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_op,
  output logic [23:0]       imm24,
  output logic [3:0]        dest
);

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       branch;
    logic       s;
  } ctrl_t;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] op;
  logic       s_bit;
  logic       is_str;

  assign cond   = instr[31:28];
  assign mode   = instr[27:26];
  assign op     = instr[24:21];
  assign s_bit  = instr[20];
  assign is_str = (mode == 2'b01) && !s_bit;

  assign src1    = instr[19:16];
  assign src2    = is_str ? instr[15:12] : instr[3:0];
  assign two_src = !instr[25] || is_str;

  // Handshake
  logic out_valid_q, out_valid_d;
  logic out_free, accept;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = flush || (!hazard && out_free);
  assign accept   = in_valid && in_ready && !flush;

  // Decode
  ctrl_t ctrl_dec;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    ctrl_dec = '0;
    case (mode)
      2'b00: begin
        ctrl_dec.wb_en = 1'b1;
        ctrl_dec.s     = s_bit;
        case (op)
          4'b1101: ctrl_dec.exe_cmd = 4'b0001; // MOV
          4'b1111: ctrl_dec.exe_cmd = 4'b1001; // MVN
          4'b0100: ctrl_dec.exe_cmd = 4'b0010; // ADD
          4'b0101: ctrl_dec.exe_cmd = 4'b0011; // ADC
          4'b0010: ctrl_dec.exe_cmd = 4'b0100; // SUB
          4'b0110: ctrl_dec.exe_cmd = 4'b0101; // SBC
          4'b0000: ctrl_dec.exe_cmd = 4'b0110; // AND
          4'b1100: ctrl_dec.exe_cmd = 4'b0111; // ORR
          4'b0001: ctrl_dec.exe_cmd = 4'b1000; // EOR
          4'b1010: begin                       // CMP: flags only
            ctrl_dec.exe_cmd = 4'b0100;
            ctrl_dec.wb_en   = 1'b0;
            ctrl_dec.s       = 1'b1;
          end
          4'b1000: begin                       // TST: flags only
            ctrl_dec.exe_cmd = 4'b0110;
            ctrl_dec.wb_en   = 1'b0;
            ctrl_dec.s       = 1'b1;
          end
          default: ctrl_dec = '0;              // unsupported op, s included
        endcase
      end
      2'b01: begin
        ctrl_dec.exe_cmd  = 4'b0010;           // address = Rn + offset
        ctrl_dec.mem_r_en = s_bit;             // LDR
        ctrl_dec.wb_en    = s_bit;
        ctrl_dec.mem_w_en = !s_bit;            // STR
      end
      2'b10: ctrl_dec.branch = 1'b1;
      default: ctrl_dec = '0;
    endcase
  end

  // Condition check on sr = {N,Z,C,V}
  logic cond_pass;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = sr[2];                           // EQ
      4'b0001: cond_pass = !sr[2];                          // NE
      4'b0010: cond_pass = sr[1];                           // CS
      4'b0011: cond_pass = !sr[1];                          // CC
      4'b0100: cond_pass = sr[3];                           // MI
      4'b0101: cond_pass = !sr[3];                          // PL
      4'b0110: cond_pass = sr[0];                           // VS
      4'b0111: cond_pass = !sr[0];                          // VC
      4'b1000: cond_pass = sr[1] && !sr[2];                 // HI
      4'b1001: cond_pass = !sr[1] || sr[2];                 // LS
      4'b1010: cond_pass = (sr[3] == sr[0]);                // GE
      4'b1011: cond_pass = (sr[3] != sr[0]);                // LT
      4'b1100: cond_pass = !sr[2] && (sr[3] == sr[0]);      // GT
      4'b1101: cond_pass = sr[2] || (sr[3] != sr[0]);       // LE
      4'b1110: cond_pass = 1'b1;                            // AL
      default: cond_pass = 1'b0;                            // 1111 never
    endcase
  end

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rn_val, rm_val;

  // NOTE: the register file is reset like any other state so reads after reset are defined; this blocks mapping it to a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else begin
      // Indices >= NUM_REGS match no entry, so those writes drop out.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wb_en && (wb_dest == 4'(r))) rf_q[r] <= wb_data;
      end
    end
  end

  always_comb begin
    rn_val = '0;
    rm_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (src1 == 4'(r)) rn_val = rf_q[r];
      if (src2 == 4'(r)) rm_val = rf_q[r];
    end
`ifdef WB_BYPASS_EN
    // Write-through: forward the value being written this edge.
    if (wb_en && (int'(wb_dest) < NUM_REGS)) begin
      if (wb_dest == src1) rn_val = wb_data;
      if (wb_dest == src2) rm_val = wb_data;
    end
`endif
  end

  // ID/EX entry
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] val_rn_q, val_rn_d, val_rm_q, val_rm_d;
  logic              imm_q, imm_d;
  logic [11:0]       shift_op_q, shift_op_d;
  logic [23:0]       imm24_q, imm24_d;
  logic [3:0]        dest_q, dest_d;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    val_rn_d    = val_rn_q;
    val_rm_d    = val_rm_q;
    imm_d       = imm_q;
    shift_op_d  = shift_op_q;
    imm24_d     = imm24_q;
    dest_d      = dest_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      // A failed condition still issues, but as a no-op.
      ctrl_d      = cond_pass ? ctrl_dec : '0;
      val_rn_d    = rn_val;
      val_rm_d    = rm_val;
      imm_d       = instr[25];
      shift_op_d  = instr[11:0];
      imm24_d     = instr[23:0];
      dest_d      = instr[15:12];
    end else if (out_free) begin
      // Drain or hazard bubble: only the valid bit drops.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      val_rn_q    <= '0;
      val_rm_q    <= '0;
      imm_q       <= 1'b0;
      shift_op_q  <= '0;
      imm24_q     <= '0;
      dest_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      val_rn_q    <= val_rn_d;
      val_rm_q    <= val_rm_d;
      imm_q       <= imm_d;
      shift_op_q  <= shift_op_d;
      imm24_q     <= imm24_d;
      dest_q      <= dest_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exe_cmd   = ctrl_q.exe_cmd;
  assign mem_r_en  = ctrl_q.mem_r_en;
  assign mem_w_en  = ctrl_q.mem_w_en;
  assign wb_en_o   = ctrl_q.wb_en;
  assign branch    = ctrl_q.branch;
  assign s_o       = ctrl_q.s;
  assign val_rn    = val_rn_q;
  assign val_rm    = val_rm_q;
  assign imm       = imm_q;
  assign shift_op  = shift_op_q;
  assign imm24     = imm24_q;
  assign dest      = dest_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe: an abstract model of the stage is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations. A random phase ends the run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_id_stage_pipe;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic              clk, rst;
  logic [31:0]       instr;
  logic              in_valid, in_ready;
  logic [3:0]        sr;
  logic              hazard, flush;
  logic              wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        src1, src2;
  logic              two_src;
  logic              out_valid, out_ready;
  logic [3:0]        exe_cmd;
  logic              mem_r_en, mem_w_en, wb_en_o, branch, s_o;
  logic [DATA_W-1:0] val_rn, val_rm;
  logic              imm;
  logic [11:0]       shift_op;
  logic [23:0]       imm24;
  logic [3:0]        dest;

  id_stage_pipe #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .sr(sr), .hazard(hazard), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .src1(src1), .src2(src2), .two_src(two_src),
    .out_valid(out_valid), .out_ready(out_ready), .exe_cmd(exe_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_o(wb_en_o), .branch(branch),
    .s_o(s_o), .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_op(shift_op),
    .imm24(imm24), .dest(dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] cmd;
    logic       mr, mw, wb, br, s;
  } ctl_t;

  // ALU command per data-processing opcode; mask marks the supported ones.
  localparam logic [3:0] ALU_CMD [16] = '{
    4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
    4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};
  localparam logic [15:0] ALU_KNOWN = 16'hB577;

  // ARM pairs conditions: cond[3:1] picks a predicate, cond[0] inverts it
  // (so 1110 is always and 1111 is never).
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic ctl_t ref_ctl(input logic [31:0] ins, input logic [3:0] f);
    ctl_t c;
    logic [3:0] op;
    c  = '0;
    op = ins[24:21];
    if (!cond_ok(ins[31:28], f)) return c;
    case (ins[27:26])
      2'b00: if (ALU_KNOWN[op]) begin
        c.cmd = ALU_CMD[op];
        if (op == 4'b1000 || op == 4'b1010) begin
          c.s = 1'b1;
        end else begin
          c.wb = 1'b1;
          c.s  = ins[20];
        end
      end
      2'b01: begin
        c.cmd = 4'b0010;
        if (ins[20]) begin c.mr = 1'b1; c.wb = 1'b1; end
        else         c.mw = 1'b1;
      end
      2'b10: c.br = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  logic [DATA_W-1:0] m_rf [NUM_REGS];
  logic              m_valid;
  ctl_t              m_ctl;
  logic [DATA_W-1:0] m_rn, m_rm;
  logic              m_imm;
  logic [11:0]       m_shift;
  logic [23:0]       m_imm24;
  logic [3:0]        m_dest;

  function automatic logic [DATA_W-1:0] ref_read(input logic [3:0] idx);
`ifdef WB_BYPASS_EN
    if (wb_en && wb_dest == idx && int'(idx) < NUM_REGS) return wb_data;
`endif
    return (int'(idx) < NUM_REGS) ? m_rf[idx] : '0;
  endfunction

  logic       e_str, e_two, e_ready, e_take;
  logic [3:0] e_src2;
  assign e_str   = (instr[27:26] == 2'b01) && !instr[20];
  assign e_src2  = e_str ? instr[15:12] : instr[3:0];
  assign e_two   = !instr[25] || e_str;
  assign e_ready = flush || (!hazard && (!m_valid || out_ready));
  assign e_take  = in_valid && e_ready && !flush;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_rf[i] <= '0;
      m_valid <= 1'b0; m_ctl <= '0; m_rn <= '0; m_rm <= '0;
      m_imm <= 1'b0; m_shift <= '0; m_imm24 <= '0; m_dest <= '0;
    end else begin
      if (flush) begin
        m_valid <= 1'b0;
        m_ctl   <= '0;
      end else if (e_take) begin
        m_valid <= 1'b1;
        m_ctl   <= ref_ctl(instr, sr);
        m_rn    <= ref_read(instr[19:16]);
        m_rm    <= ref_read(e_src2);
        m_imm   <= instr[25];
        m_shift <= instr[11:0];
        m_imm24 <= instr[23:0];
        m_dest  <= instr[15:12];
      end else if (!m_valid || out_ready) begin
        m_valid <= 1'b0;
      end
      if (wb_en && int'(wb_dest) < NUM_REGS) m_rf[wb_dest] <= wb_data;
    end
  end

  // Compare process: every falling edge, all outputs.
  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("ctrl", 64'({exe_cmd, mem_r_en, mem_w_en, wb_en_o, branch, s_o}), 64'(m_ctl));
    check("operands", {val_rn, val_rm}, {m_rn, m_rm});
    check("fields", 64'({imm, shift_op, imm24, dest}), 64'({m_imm, m_shift, m_imm24, m_dest}));
    check("comb", 64'({in_ready, src1, src2, two_src}), 64'({e_ready, instr[19:16], e_src2, e_two}));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD   R1,R2,R3
  localparam logic [31:0] I_ADDNE = 32'h10821003; // ADDNE R1,R2,R3
  localparam logic [31:0] I_ADDNV = 32'hF0821003; // cond 1111
  localparam logic [31:0] I_RSB   = 32'hE0621003; // unsupported op 0011
  localparam logic [31:0] I_STR   = 32'hE5824000; // STR R4,[R2]
  localparam logic [31:0] I_LDR   = 32'hE5925000; // LDR R5,[R2]
  localparam logic [31:0] I_MOV   = 32'hE3A06055; // MOV R6,#0x55
  localparam logic [31:0] I_CMP   = 32'hE1520003; // CMP R2,R3
  localparam logic [31:0] I_B     = 32'hEA000010; // B   +0x10

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [DATA_W-1:0] val);
    wb_en = 1'b1; wb_dest = idx; wb_data = val;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr = ins; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; instr = '0; in_valid = 1'b0; sr = '0; hazard = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("lit_reset_valid", 64'(out_valid), 64'd0);
    check("lit_reset_ready", 64'(in_ready), 64'd1);
    check("lit_reset_rn", 64'(val_rn), 64'd0);
    rst = 1'b1;

    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);

    issue(I_ADD);
    check("lit_add_valid", 64'(out_valid), 64'd1);
    check("lit_add_cmd", 64'(exe_cmd), 64'h2);
    check("lit_add_rn", 64'(val_rn), 64'd5);
    check("lit_add_rm", 64'(val_rm), 64'd7);
    check("lit_add_wb", 64'(wb_en_o), 64'd1);
    check("lit_add_dest", 64'(dest), 64'd1);

    instr = I_STR; #1;
    check("lit_str_src2", 64'(src2), 64'd4);
    check("lit_str_two", 64'(two_src), 64'd1);
    issue(I_STR);
    check("lit_str_mw", 64'(mem_w_en), 64'd1);
    check("lit_str_wb", 64'(wb_en_o), 64'd0);
    check("lit_str_cmd", 64'(exe_cmd), 64'h2);

    sr = 4'b0100;
    issue(I_ADDNE);
    check("lit_ne_valid", 64'(out_valid), 64'd1);
    check("lit_ne_ctrl", 64'({exe_cmd, mem_r_en, mem_w_en, wb_en_o, branch, s_o}), 64'd0);
    sr = 4'b0000;

    // Hazard for two cycles, accept on the cycle it drops.
    instr = I_ADD; in_valid = 1'b1; hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("lit_haz_ready", 64'(in_ready), 64'd0);
      tick();
      check("lit_haz_valid", 64'(out_valid), 64'd0);
    end
    hazard = 1'b0;
    #1 check("lit_haz_release", 64'(in_ready), 64'd1);
    tick();
    check("lit_haz_accept", 64'(out_valid), 64'd1);
    in_valid = 1'b0;

    // Back-pressure for three cycles after an accept.
    issue(I_MOV);
    out_ready = 1'b0; instr = I_CMP; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("lit_bp_ready", 64'(in_ready), 64'd0);
      tick();
      check("lit_bp_hold", 64'({out_valid, exe_cmd, dest, imm24}), 64'({1'b1, 4'h1, 4'h6, 24'hA06055}));
    end
    out_ready = 1'b1;
    #1 check("lit_bp_release", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("lit_cmp_ctrl", 64'({exe_cmd, wb_en_o, s_o}), 64'({4'h4, 1'b0, 1'b1}));

    // Flush of a held entry.
    out_ready = 1'b0; issue(I_CMP);
    flush = 1'b1; instr = I_ADD; in_valid = 1'b1;
    #1 check("lit_flush_ready", 64'(in_ready), 64'd1);
    tick();
    check("lit_flush_valid", 64'(out_valid), 64'd0);
    check("lit_flush_ctrl", 64'({exe_cmd, s_o}), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Simultaneous write and read of R2.
    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hAB;
    issue(I_ADD);
    wb_en = 1'b0;
`ifdef WB_BYPASS_EN
    check("lit_wb_same_cycle", 64'(val_rn), 64'hAB);
`else
    check("lit_wb_same_cycle", 64'(val_rn), 64'd5);
`endif
    issue(I_ADD);
    check("lit_wb_next_cycle", 64'(val_rn), 64'hAB);

    issue(I_LDR);
    check("lit_ldr_ctrl", 64'({exe_cmd, mem_r_en, mem_w_en, wb_en_o}), 64'({4'h2, 3'b101}));
    issue(I_B);
    check("lit_b_ctrl", 64'({branch, exe_cmd, imm24}), 64'({1'b1, 4'h0, 24'h000010}));
    issue(I_ADDNV);
    check("lit_nv_ctrl", 64'({out_valid, exe_cmd, wb_en_o}), 64'({1'b1, 4'h0, 1'b0}));
    issue(I_RSB);
    check("lit_rsb_ctrl", 64'({out_valid, wb_en_o, s_o}), 64'({1'b1, 2'b00}));

    // Condition sweep, checked by the model.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f += 5) begin
        sr = 4'(f);
        issue({4'(c), I_ADD[27:0]});
      end
    end
    sr = '0;

    // Reset asserted while stalled.
    issue(I_ADD);
    out_ready = 1'b0; instr = I_MOV; in_valid = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1 check("lit_rst_stall_valid", 64'({out_valid, val_rn}), 64'd0);
    tick();
    rst = 1'b1;
    #1 check("lit_rst_release_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instr = $urandom();
      if ($urandom_range(1, 0) == 1) instr[31:28] = 4'hE;
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      hazard    = ($urandom_range(4, 0) == 0);
      flush     = ($urandom_range(7, 0) == 0);
      sr        = 4'($urandom());
      wb_en     = ($urandom_range(1, 0) == 1);
      wb_dest   = 4'($urandom());
      wb_data   = $urandom();
      tick();
    end
    in_valid = 1'b0; hazard = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
